// File: rtl/radar_sim_pkg.sv
// -----------------------------------------------------------------------------
// radar_sim_pkg
// Shared types and default constants for the radar simulator timing chain.
//   acp_state_e     : azimuth pulse generator state (IDLE, PULSE)
//   ACP_PER_REV_DEF : default ACP pulses per antenna revolution
//   PULSE_WIDTH_DEF : default ACP/ARP high time in system clock cycles
// -----------------------------------------------------------------------------
package radar_sim_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } acp_state_e;

    localparam int ACP_PER_REV_DEF = 4096;
    localparam int PULSE_WIDTH_DEF = 4;

endpackage : radar_sim_pkg

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Two-flop rising-edge detector for a level that is synchronous to clk.
// While rst_n is low both flops track the input, so a level that is already
// high at reset release is not reported as an edge.
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   sig   in  level to watch (treated as data)
//   rise  out one-cycle high when sig went 0 -> 1
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic t0_r;
    logic t1_r;

    // Sample history; during reset both stages follow the input level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t0_r <= sig;
            t1_r <= sig;
        end else begin
            t0_r <= sig;
            t1_r <= t0_r;
        end
    end

    assign rise = t0_r & ~t1_r;

endmodule : rise_detect

// File: rtl/acp_arp_gen.sv
// -----------------------------------------------------------------------------
// acp_arp_gen
// Azimuth pulse generator. Each accepted rising edge of TICK_CLK produces one
// PULSE_WIDTH-cycle ACP pulse and advances AZIMUTH; the ACP that wraps
// AZIMUTH back to 0 also carries the ARP (north) pulse. Edges arriving while
// a pulse is still running are dropped and latched in the sticky OVERRUN.
//   CLK      in  system clock
//   RST_N    in  synchronous active-low reset
//   EN       in  tick acceptance enable (sampled in IDLE only)
//   TICK_CLK in  divided clock, used as data
//   CLR_OVR  in  clears OVERRUN (a simultaneous set wins)
//   ACP      out azimuth change pulse
//   ARP      out north pulse, coincident with the wrapping ACP
//   AZIMUTH  out ACP count since the last ARP
//   OVERRUN  out sticky dropped-tick flag
// -----------------------------------------------------------------------------
module acp_arp_gen
    import radar_sim_pkg::*;
#(
    parameter int ACP_PER_REV = ACP_PER_REV_DEF,
    parameter int PULSE_WIDTH = PULSE_WIDTH_DEF,
    parameter int AZ_W        = 12
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            TICK_CLK,
    input  logic            CLR_OVR,
    output logic            ACP,
    output logic            ARP,
    output logic [AZ_W-1:0] AZIMUTH,
    output logic            OVERRUN
);

    localparam int              CNT_W    = $clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [AZ_W-1:0]  AZ_LAST  = AZ_W'(ACP_PER_REV - 1);

    acp_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic            acp_r;
    logic            arp_r;
    logic [AZ_W-1:0] az_r;
    logic            ovr_r;
    logic            tick_rise_s;
    logic            az_wrap_s;

    rise_detect u_tick_rise (
        .clk   (CLK),
        .rst_n (RST_N),
        .sig   (TICK_CLK),
        .rise  (tick_rise_s)
    );

    // Wrap is an explicit compare so non-power-of-two revolutions work.
    assign az_wrap_s = (az_r == AZ_LAST);

    // Pulse sequencer: accepts a tick in IDLE, times the pulse in PULSE.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            acp_r   <= 1'b0;
            arp_r   <= 1'b0;
            az_r    <= {AZ_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (EN && tick_rise_s) begin
                        acp_r   <= 1'b1;
                        arp_r   <= az_wrap_s;
                        cnt_r   <= CNT_LOAD;
                        az_r    <= az_wrap_s ? {AZ_W{1'b0}} : az_r + AZ_W'(1);
                        state_r <= PULSE;
                    end else begin
                        acp_r   <= 1'b0;
                        arp_r   <= 1'b0;
                    end
                end
                PULSE: begin
                    // Edges seen here are dropped; only the overrun flag reacts.
                    if (cnt_r == CNT_W'(0)) begin
                        acp_r   <= 1'b0;
                        arp_r   <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    acp_r   <= 1'b0;
                    arp_r   <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: an edge during a pulse sets it, and setting beats clearing.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovr_r <= 1'b0;
        end else if (tick_rise_s && (state_r == PULSE)) begin
            ovr_r <= 1'b1;
        end else if (CLR_OVR) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign ACP     = acp_r;
    assign ARP     = arp_r;
    assign AZIMUTH = az_r;
    assign OVERRUN = ovr_r;

endmodule : acp_arp_gen

// File: tb/tb_acp_arp_gen.sv
// -----------------------------------------------------------------------------
// tb_acp_arp_gen
// Directed bench for acp_arp_gen with ACP_PER_REV=8, PULSE_WIDTH=4, AZ_W=12.
// A negedge monitor measures every ACP/ARP pulse width and logs AZIMUTH at
// each ACP rise; directed scenarios check counts and flags afterwards.
// -----------------------------------------------------------------------------
module tb_acp_arp_gen;

    localparam int N_REV = 8;
    localparam int PW    = 4;
    localparam int AZW   = 12;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           tick;
    logic           clr_ovr;
    logic           acp;
    logic           arp;
    logic [AZW-1:0] azimuth;
    logic           overrun;

    int checks_cnt;
    int errors_cnt;

    bit mon_en;
    bit acp_q;
    bit arp_q;
    int acp_w;
    int arp_w;
    int acp_rises;
    int arp_rises;
    int az_log[$];

    acp_arp_gen #(
        .ACP_PER_REV (N_REV),
        .PULSE_WIDTH (PW),
        .AZ_W        (AZW)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .EN       (en),
        .TICK_CLK (tick),
        .CLR_OVR  (clr_ovr),
        .ACP      (acp),
        .ARP      (arp),
        .AZIMUTH  (azimuth),
        .OVERRUN  (overrun)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor: widths, rise counts and ARP/AZIMUTH coincidence.
    always @(negedge clk) begin
        if (mon_en) begin
            if (acp) acp_w++;
            if (arp) arp_w++;
            if (acp && !acp_q) begin
                acp_rises++;
                az_log.push_back(int'(azimuth));
                check("arp_with_wrap", {31'd0, arp}, {31'd0, (azimuth == 12'd0)});
            end
            if (arp && !arp_q) arp_rises++;
            if (!acp && acp_q) begin
                check("acp_width", acp_w, PW);
                acp_w = 0;
            end
            if (!arp && arp_q) begin
                check("arp_width", arp_w, PW);
                arp_w = 0;
            end
        end else begin
            acp_w = 0;
            arp_w = 0;
        end
        acp_q = acp;
        arp_q = arp;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acp_rises = 0;
        arp_rises = 0;
        az_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        clear_mon();
    endtask

    // One tick: hi cycles high then lo cycles low; called at posedge+1.
    task automatic tick_once(input int hi, input int lo);
        tick = 1'b1;
        repeat (hi) cyc();
        tick = 1'b0;
        repeat (lo) cyc();
    endtask

    initial begin
        int exp_az[9];
        checks_cnt = 0;
        errors_cnt = 0;
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b1;
        tick    = 1'b1;
        clr_ovr = 1'b0;

        // Reset with TICK_CLK already high: no spurious pulse afterwards.
        repeat (3) cyc();
        check("rst_acp", {31'd0, acp}, 32'd0);
        check("rst_arp", {31'd0, arp}, 32'd0);
        check("rst_az", {20'd0, azimuth}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n  = 1'b1;
        clear_mon();
        mon_en = 1'b1;
        repeat (10) cyc();
        check("hi_release_acps", acp_rises, 0);
        check("hi_release_az", {20'd0, azimuth}, 32'd0);
        check("hi_release_ovr", {31'd0, overrun}, 32'd0);
        tick = 1'b0;
        repeat (3) cyc();

        // Five ticks, period 30, with latency check on the first.
        do_reset();
        tick = 1'b1;
        cyc();
        check("lat_acp_k", {31'd0, acp}, 32'd0);
        cyc();
        check("lat_acp_k1", {31'd0, acp}, 32'd1);
        check("lat_az_k1", {20'd0, azimuth}, 32'd1);
        repeat (13) cyc();
        tick = 1'b0;
        repeat (15) cyc();
        for (int i = 0; i < 4; i++) tick_once(15, 15);
        check("p30_acps", acp_rises, 5);
        check("p30_az", {20'd0, azimuth}, 32'd5);
        check("p30_arps", arp_rises, 0);
        check("p30_ovr", {31'd0, overrun}, 32'd0);

        // Nine ticks through a revolution of 8: one ARP, wrap to 0.
        do_reset();
        for (int i = 0; i < 9; i++) tick_once(5, 5);
        repeat (5) cyc();
        exp_az = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        check("rev_acps", acp_rises, 9);
        check("rev_arps", arp_rises, 1);
        for (int i = 0; i < 9; i++) begin
            if (i < az_log.size()) check("rev_az_seq", az_log[i], exp_az[i]);
        end

        // EN low during ticks 3 and 4 of 6.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            tick_once(5, 5);
        end
        en = 1'b1;
        check("en_acps", acp_rises, 4);
        check("en_az", {20'd0, azimuth}, 32'd4);
        check("en_ovr", {31'd0, overrun}, 32'd0);

        // Ticks every 3 cycles: every other one dropped, sticky overrun.
        do_reset();
        for (int i = 0; i < 8; i++) tick_once(1, 2);
        repeat (10) cyc();
        check("fast_acps", acp_rises, 4);
        check("fast_az", {20'd0, azimuth}, 32'd4);
        check("fast_ovr_sticky", {31'd0, overrun}, 32'd1);
        clr_ovr = 1'b1;
        cyc();
        clr_ovr = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        repeat (5) cyc();

        // CLR_OVR held while ticks continue: a drop still sets the flag.
        clr_ovr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            check("set_wins_ovr", {31'd0, overrun}, (i % 2 == 1) ? 32'd1 : 32'd0);
            cyc();
        end
        clr_ovr = 1'b0;
        repeat (8) cyc();
        check("fast2_acps", acp_rises, 7);
        check("fast2_az", {20'd0, azimuth}, 32'd7);

        // Reset two cycles into a pulse truncates it.
        do_reset();
        mon_en = 1'b0;
        tick = 1'b1;
        repeat (4) cyc();
        check("mid_pre_acp", {31'd0, acp}, 32'd1);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_acp", {31'd0, acp}, 32'd0);
        check("mid_rst_az", {20'd0, azimuth}, 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        repeat (3) cyc();
        check("mid_post_acp", {31'd0, acp}, 32'd0);
        clear_mon();
        mon_en = 1'b1;
        tick_once(5, 10);
        check("resume_acps", acp_rises, 1);
        check("resume_az", {20'd0, azimuth}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_acp_arp_gen
